// File: rtl/ghost_pkg.sv
// ghost_pkg: shared constants and types for the ghost movers.
//   Coordinate widths, waypoint type, ghost #4 patrol loop and reset state.
//   next_idx() wraps a waypoint index around the loop.
package ghost_pkg;

  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned NUM_WP = 6;
  localparam int unsigned IDX_W  = 3;

  typedef logic [X_W-1:0]   x_t;
  typedef logic [Y_W-1:0]   y_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    x_t x;
    y_t y;
  } wp_t;

  // Entry 0 sits in the low bits, so GHOST4_WP[i] is waypoint i.
  localparam wp_t [NUM_WP-1:0] GHOST4_WP = {
    wp_t'{x: x_t'(608), y: y_t'(416)},  // 5
    wp_t'{x: x_t'(608), y: y_t'(208)},  // 4
    wp_t'{x: x_t'(416), y: y_t'(208)},  // 3
    wp_t'{x: x_t'(416), y: y_t'(304)},  // 2
    wp_t'{x: x_t'(576), y: y_t'(304)},  // 1
    wp_t'{x: x_t'(576), y: y_t'(416)}   // 0
  };

  localparam x_t   GHOST4_RST_X   = x_t'(576);
  localparam y_t   GHOST4_RST_Y   = y_t'(416);
  localparam idx_t GHOST4_RST_IDX = idx_t'(1);

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(NUM_WP - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/ghost_four_if.sv
// ghost_four_if: position bus from the ghost #4 mover to its consumers.
//   x      ghost top-left x, pixels
//   y      ghost top-left y, pixels
//   freeze hold request (only with GHOST_FOUR_FREEZE_EN defined)
// Modports: master = the mover, slave = renderer / crash checker.
interface ghost_four_if;
  import ghost_pkg::*;

  x_t x;
  y_t y;
`ifdef GHOST_FOUR_FREEZE_EN
  logic freeze;

  modport master (output x, output y, input  freeze);
  modport slave  (input  x, input  y, output freeze);
`else
  modport master (output x, output y);
  modport slave  (input  x, input  y);
`endif
endinterface

// File: rtl/step_prescaler.sv
// step_prescaler: divides clk into a one-cycle step tick.
//   clk  system clock
//   rst  asynchronous active-high reset (count returns to 0)
//   en   count enable; while low the count and tick are held off
//   tick high for the cycle in which the count sits at STEP_DIV-1
module step_prescaler #(
  parameter int unsigned STEP_DIV = 1_000_000,
  parameter int unsigned STEP_W   = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(STEP_DIV - 1);

  logic [STEP_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ghost_four.sv
// ghost_four: autonomous ghost #4 mover walking a fixed closed patrol loop,
// one pixel per step tick, toward the current waypoint (x first, then y).
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  ghost_four_if.master: x, y out (registered); freeze in when
//        GHOST_FOUR_FREEZE_EN is defined (holds prescaler, position, index)
module ghost_four
  import ghost_pkg::*;
#(
  parameter int unsigned STEP_DIV = 1_000_000,
  parameter int unsigned STEP_W   = 20
) (
  input logic           clk,
  input logic           rst,
  ghost_four_if.master  bus
);

  logic en;
  logic tick;
  x_t   x_q, x_n;
  y_t   y_q, y_n;
  idx_t tidx_q;
  wp_t  tgt;
  logic arrive;

`ifdef GHOST_FOUR_FREEZE_EN
  assign en = ~bus.freeze;
`else
  assign en = 1'b1;
`endif

  step_prescaler #(
    .STEP_DIV (STEP_DIV),
    .STEP_W   (STEP_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    tgt = GHOST4_WP[tidx_q];
    x_n = x_q;
    y_n = y_q;
    if (x_q < tgt.x) begin
      x_n = x_q + 1'b1;
    end else if (x_q > tgt.x) begin
      x_n = x_q - 1'b1;
    end else if (y_q < tgt.y) begin
      y_n = y_q + 1'b1;
    end else if (y_q > tgt.y) begin
      y_n = y_q - 1'b1;
    end
    // Covers both the arriving step and a tick taken while already on target.
    arrive = (x_n == tgt.x) && (y_n == tgt.y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= GHOST4_RST_X;
      y_q    <= GHOST4_RST_Y;
      tidx_q <= GHOST4_RST_IDX;
    end else if (tick) begin
      x_q <= x_n;
      y_q <= y_n;
      if (arrive) begin
        tidx_q <= next_idx(tidx_q);
      end
    end
  end

  assign bus.x = x_q;
  assign bus.y = y_q;

endmodule

// File: tb/tb_ghost_four.sv
// tb_ghost_four: directed self-checking bench for ghost_four with STEP_DIV=4.
// Exercises the freeze feature when GHOST_FOUR_FREEZE_EN is defined.
module tb_ghost_four;
  import ghost_pkg::*;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic bounds_on = 1'b0;

  always #5 clk = ~clk;

  ghost_four_if bus ();

  ghost_four #(
    .STEP_DIV (DIV),
    .STEP_W   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Expected position after k ticks from reset, from the segment table.
  function automatic void model_pos(input int k, output int ex, output int ey);
    int m;
    m = k % 800;
    if (m <= 112)      begin ex = 576;             ey = 416 - m;         end
    else if (m <= 272) begin ex = 576 - (m - 112); ey = 304;             end
    else if (m <= 368) begin ex = 416;             ey = 304 - (m - 272); end
    else if (m <= 560) begin ex = 416 + (m - 368); ey = 208;             end
    else if (m <= 768) begin ex = 608;             ey = 208 + (m - 560); end
    else               begin ex = 608 - (m - 768); ey = 416;             end
  endfunction

  always @(negedge clk) begin
    if (bounds_on && !rst) begin
      checks++;
      if (!(bus.x >= 416 && bus.x <= 608 && bus.y >= 208 && bus.y <= 416)) begin
        errors++;
        $display("FAIL bounds got (%0d,%0d) required inside x 416..608 y 208..416",
                 bus.x, bus.y);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic advance(input int n);
    repeat (n * DIV) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.x !== 10'd576 || bus.y !== 9'd416) begin
      errors++;
      $display("FAIL reset_async got (%0d,%0d) required (576,416)", bus.x, bus.y);
    end
    bounds_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.x !== 10'd576 || bus.y !== 9'd416) begin
      errors++;
      $display("FAIL reset_hold got (%0d,%0d) required (576,416)", bus.x, bus.y);
    end
  endtask

  task automatic test_first_step();
    @(posedge clk);
    #1;
    checks++;
    if (bus.x !== 10'd576 || bus.y !== 9'd415) begin
      errors++;
      $display("FAIL first_step got (%0d,%0d) required (576,415)", bus.x, bus.y);
    end
    advance(111);
    checks++;
    if (bus.x !== 10'd576 || bus.y !== 9'd304) begin
      errors++;
      $display("FAIL wp1_arrive got (%0d,%0d) required (576,304)", bus.x, bus.y);
    end
    advance(1);
    checks++;
    if (bus.x !== 10'd575 || bus.y !== 9'd304) begin
      errors++;
      $display("FAIL turn_left got (%0d,%0d) required (575,304)", bus.x, bus.y);
    end
  endtask

  task automatic test_full_loop();
    int ex, ey;
    apply_reset();
    for (int k = 1; k <= 800; k++) begin
      advance(1);
      model_pos(k, ex, ey);
      checks++;
      if (bus.x !== x_t'(ex) || bus.y !== y_t'(ey)) begin
        errors++;
        $display("FAIL loop tick %0d got (%0d,%0d) required (%0d,%0d)",
                 k, bus.x, bus.y, ex, ey);
      end
      case (k)
        368: begin
          checks++;
          if (bus.x !== 10'd416 || bus.y !== 9'd208) begin
            errors++;
            $display("FAIL corner368 got (%0d,%0d) required (416,208)", bus.x, bus.y);
          end
        end
        560: begin
          checks++;
          if (bus.x !== 10'd608 || bus.y !== 9'd208) begin
            errors++;
            $display("FAIL corner560 got (%0d,%0d) required (608,208)", bus.x, bus.y);
          end
        end
        768: begin
          checks++;
          if (bus.x !== 10'd608 || bus.y !== 9'd416) begin
            errors++;
            $display("FAIL corner768 got (%0d,%0d) required (608,416)", bus.x, bus.y);
          end
        end
        800: begin
          checks++;
          if (bus.x !== 10'd576 || bus.y !== 9'd416) begin
            errors++;
            $display("FAIL loop_close got (%0d,%0d) required (576,416)", bus.x, bus.y);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_async_reset();
    int ex, ey;
    apply_reset();
    advance(200);
    checks++;
    if (bus.x !== 10'd488 || bus.y !== 9'd304) begin
      errors++;
      $display("FAIL pre_reset got (%0d,%0d) required (488,304)", bus.x, bus.y);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.x !== 10'd576 || bus.y !== 9'd416) begin
      errors++;
      $display("FAIL midseg_reset got (%0d,%0d) required (576,416)", bus.x, bus.y);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 250; k++) begin
      advance(1);
      model_pos(k, ex, ey);
      checks++;
      if (bus.x !== x_t'(ex) || bus.y !== y_t'(ey)) begin
        errors++;
        $display("FAIL replay tick %0d got (%0d,%0d) required (%0d,%0d)",
                 k, bus.x, bus.y, ex, ey);
      end
    end
  endtask

  task automatic test_two_loops();
    int ex, ey;
    apply_reset();
    for (int k = 1; k <= 1600; k++) begin
      advance(1);
      model_pos(k, ex, ey);
      checks++;
      if (bus.x !== x_t'(ex) || bus.y !== y_t'(ey)) begin
        errors++;
        $display("FAIL two_loops tick %0d got (%0d,%0d) required (%0d,%0d)",
                 k, bus.x, bus.y, ex, ey);
      end
    end
  endtask

`ifdef GHOST_FOUR_FREEZE_EN
  task automatic test_freeze();
    int ex, ey;
    apply_reset();
    advance(10);
    bus.freeze = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (bus.x !== 10'd576 || bus.y !== 9'd406) begin
      errors++;
      $display("FAIL freeze_hold got (%0d,%0d) required (576,406)", bus.x, bus.y);
    end
    bus.freeze = 1'b0;
    repeat (DIV - 1) @(posedge clk);
    #1;
    checks++;
    if (bus.x !== 10'd576 || bus.y !== 9'd406) begin
      errors++;
      $display("FAIL freeze_resume_early got (%0d,%0d) required (576,406)", bus.x, bus.y);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.x !== 10'd576 || bus.y !== 9'd405) begin
      errors++;
      $display("FAIL freeze_resume got (%0d,%0d) required (576,405)", bus.x, bus.y);
    end
    for (int k = 12; k <= 120; k++) begin
      advance(1);
      model_pos(k, ex, ey);
      checks++;
      if (bus.x !== x_t'(ex) || bus.y !== y_t'(ey)) begin
        errors++;
        $display("FAIL freeze_after tick %0d got (%0d,%0d) required (%0d,%0d)",
                 k, bus.x, bus.y, ex, ey);
      end
    end
  endtask
`endif

  initial begin
`ifdef GHOST_FOUR_FREEZE_EN
    bus.freeze = 1'b0;
`endif
    test_reset();
    test_first_step();
    test_full_loop();
    test_async_reset();
    test_two_loops();
`ifdef GHOST_FOUR_FREEZE_EN
    test_freeze();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
